// File: rtl/serie_paralelo_pkg.sv
// Shared constants and state encoding for the serial link (transmitter and receiver).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serie_paralelo_pkg;

    // Bits per parallel word on the link
    localparam int WORD_W = 8;

    // Idle / alignment symbol sent whenever the transmitter has no data
    localparam logic [WORD_W-1:0] COMMA_BC = 8'hBC;

    // Consecutive aligned commas needed before the receiver trusts its alignment
    localparam int SYNC_CNT_DEF = 4;

    // Receiver alignment state
    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        ALIGN  = 2'd1,
        SYNC   = 2'd2
    } sync_state_t;

endpackage

// File: rtl/serie_paralelo_sync.sv
// Serial-to-parallel receiver: comma-based byte alignment, then one recovered word per WIDTH bits.
// Latency: word outputs update on the edge that samples the word's LSB (visible the next cycle).
// Backpressure: none; the serial stream is free-running and every output is a one-cycle pulse or level.
module serie_paralelo_sync
    import serie_paralelo_pkg::*;
#(
    parameter int               WIDTH      = WORD_W,
    parameter logic [WIDTH-1:0] COMMA      = COMMA_BC,
    parameter int               SYNC_COUNT = SYNC_CNT_DEF
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_inS,
    output logic [WIDTH-1:0] data_outP,
    output logic             valid_out,
    output logic             word_stb,
    output logic             active_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BC_W  = (SYNC_COUNT > 0) ? $clog2(SYNC_COUNT + 1) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [BC_W-1:0]  BC_MAX   = BC_W'(SYNC_COUNT);
    localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [BC_W-1:0]  bc_cnt;
    logic [BC_W-1:0]  bc_inc;
    logic             boundary;
    logic             comma_hit;
    sync_state_t      state;

    // Window including the bit sampled this edge; all decisions look at this, not the stale register
    always_comb begin
        sr_next     = {sr[WIDTH-2:0], data_inS};
        comma_hit   = (sr_next == COMMA);
        boundary    = (bit_cnt == BIT_LAST);
        bit_cnt_inc = boundary ? '0 : bit_cnt + CNT_W'(1);
        bc_inc      = (bc_cnt == BC_MAX) ? BC_MAX : bc_cnt + BC_ONE;
    end

    // Shift register, word counters and alignment FSM with registered outputs
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            sr         <= '0;
            bit_cnt    <= '0;
            bc_cnt     <= '0;
            state      <= UNSYNC;
            data_outP  <= '0;
            valid_out  <= 1'b0;
            word_stb   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            sr        <= sr_next;
            // Strobes are single-cycle; only a boundary in SYNC raises them again
            valid_out <= 1'b0;
            word_stb  <= 1'b0;

            case (state)
                UNSYNC: begin
                    // Slide one bit at a time until a comma appears at any phase
                    if (comma_hit) begin
                        bit_cnt <= '0;
                        bc_cnt  <= BC_ONE;
                        if (SYNC_COUNT <= 1) begin
                            state      <= SYNC;
                            active_out <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    bit_cnt <= bit_cnt_inc;
                    // Only commas landing exactly on the candidate word phase count
                    if (boundary) begin
                        if (comma_hit) begin
                            bc_cnt <= bc_inc;
                            if (bc_inc == BC_MAX) begin
                                state      <= SYNC;
                                active_out <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= '0;
                            state  <= UNSYNC;
                        end
                    end
                end

                SYNC: begin
                    bit_cnt <= bit_cnt_inc;
                    // Lock is held until reset; commas mark the word but carry no data
                    if (boundary) begin
                        word_stb <= 1'b1;
                        if (!comma_hit) begin
                            data_outP <= sr_next;
                            valid_out <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= UNSYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serie_paralelo_sync.sv
// Self-checking bench for serie_paralelo_sync: directed link scenarios plus randomized streams,
// every cycle compared against a stream-level model of comma acquisition and word delivery.
// Expected values come from the recorded bit history since the last reset.
module tb_serie_paralelo_sync;

    localparam int         SYNC_COUNT = 4;
    localparam logic [7:0] CM         = 8'hBC;
    localparam int         MAXBITS    = 4096;

    logic       clk_8f = 1'b0;
    logic       reset = 1'b1;
    logic       data_inS = 1'b0;
    logic [7:0] data_outP;
    logic       valid_out;
    logic       word_stb;
    logic       active_out;

    serie_paralelo_sync dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .data_inS   (data_inS),
        .data_outP  (data_outP),
        .valid_out  (valid_out),
        .word_stb   (word_stb),
        .active_out (active_out)
    );

    always #5 clk_8f = ~clk_8f;

    int   n_pass = 0;
    int   n_total = 0;
    logic bits [0:MAXBITS-1];
    int   n = 0;
    bit   chk_en = 1'b0;

    typedef struct packed {
        logic       act;
        logic       stb;
        logic       vld;
        logic [7:0] dat;
    } exp_t;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (bit %0d since reset)", name, got, exp, n);
    endtask

    // Byte formed by the 8 most recent bits ending at bit t (bits before reset count as 0)
    function automatic logic [7:0] win(input int t);
        logic [7:0] w;
        w = 8'h00;
        for (int i = t - 7; i <= t; i++) w = {w[6:0], (i >= 1) ? bits[i] : 1'b0};
        return w;
    endfunction

    // Outputs expected right after bit 'upto' has been sampled:
    // find the first comma that is followed by SYNC_COUNT-1 more commas at 8-bit spacing;
    // a miss at one of those spots restarts the search from the bit after the miss.
    function automatic exp_t model_eval(input int upto);
        exp_t e;
        int   t;
        int   k;
        int   ts;
        bit   pending;
        bit   failed;
        e       = '0;
        ts      = 0;
        t       = 1;
        pending = 1'b0;
        while (t <= upto && ts == 0 && !pending) begin
            if (win(t) != CM) begin
                t++;
            end else begin
                failed = 1'b0;
                k      = 1;
                while (k < SYNC_COUNT && !failed && !pending) begin
                    if (t + 8 * k > upto) pending = 1'b1;
                    else if (win(t + 8 * k) != CM) failed = 1'b1;
                    else k++;
                end
                if (failed) t = t + 8 * k + 1;
                else if (!pending) ts = t + 8 * (SYNC_COUNT - 1);
            end
        end
        if (ts != 0) begin
            e.act = 1'b1;
            if (upto > ts && (upto - ts) % 8 == 0) begin
                e.stb = 1'b1;
                e.vld = (win(upto) != CM);
            end
            for (int m = ts + 8; m <= upto; m += 8)
                if (win(m) != CM) e.dat = win(m);
        end
        return e;
    endfunction

    // Single compare process: outputs checked against the model every cycle once reset has been applied
    always @(negedge clk_8f) begin
        exp_t e;
        if (chk_en) begin
            e = model_eval(n);
            check("active_out", 8'(active_out), 8'(e.act));
            check("word_stb",   8'(word_stb),   8'(e.stb));
            check("valid_out",  8'(valid_out),  8'(e.vld));
            check("data_outP",  data_outP,      e.dat);
        end
    end

    task automatic tick(input logic b, input logic r);
        data_inS = b;
        reset    = r;
        @(posedge clk_8f);
        if (r) begin
            n      = 0;
            chk_en = 1'b1;
        end else if (n < MAXBITS - 1) begin
            n       = n + 1;
            bits[n] = b;
        end
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) tick(b[i], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 7, 0);
    endtask

    task automatic do_reset(input int cycles);
        repeat (cycles) tick(1'($urandom), 1'b1);
    endtask

    // Hand-computed expectation checked against both the DUT and the model
    task automatic pin(input string name, input string sel, input logic [7:0] lit);
        exp_t       e;
        logic [7:0] dv;
        logic [7:0] mv;
        e = model_eval(n);
        if (sel == "act") begin
            dv = 8'(active_out); mv = 8'(e.act);
        end else if (sel == "stb") begin
            dv = 8'(word_stb); mv = 8'(e.stb);
        end else if (sel == "vld") begin
            dv = 8'(valid_out); mv = 8'(e.vld);
        end else begin
            dv = data_outP; mv = e.dat;
        end
        check(name, dv, lit);
        check({name, "_model"}, mv, lit);
    endtask

    initial begin
        // Reset with random serial data
        do_reset(3);
        pin("rst_act", "act", 8'h00);
        pin("rst_dat", "dat", 8'h00);
        pin("rst_vld", "vld", 8'h00);
        pin("rst_stb", "stb", 8'h00);

        // Aligned sync: BC x4, then AA BB AC
        repeat (3) send_byte(CM);
        send_bits(CM, 7, 1);
        pin("al_act31", "act", 8'h00);
        send_bits(CM, 0, 0);
        pin("al_act32", "act", 8'h01);
        pin("al_stb32", "stb", 8'h00);
        send_byte(8'hAA);
        pin("al_dat40", "dat", 8'hAA);
        pin("al_vld40", "vld", 8'h01);
        pin("al_stb40", "stb", 8'h01);
        send_byte(8'hBB);
        pin("al_dat48", "dat", 8'hBB);
        send_bits(8'hAC, 7, 1);
        pin("al_stb55", "stb", 8'h00);
        pin("al_vld55", "vld", 8'h00);
        pin("al_dat55", "dat", 8'hBB);
        send_bits(8'hAC, 0, 0);
        pin("al_dat56", "dat", 8'hAC);
        pin("al_stb56", "stb", 8'h01);

        // Offset sync: 3 junk bits then BC x4 then 5A
        do_reset(3);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        repeat (3) send_byte(CM);
        send_bits(CM, 7, 1);
        pin("off_act34", "act", 8'h00);
        send_bits(CM, 0, 0);
        pin("off_act35", "act", 8'h01);
        send_byte(8'h5A);
        pin("off_dat43", "dat", 8'h5A);
        pin("off_vld43", "vld", 8'h01);

        // Broken sequence: BC BC BC 00 then BC x4 then 11
        do_reset(3);
        repeat (3) send_byte(CM);
        send_byte(8'h00);
        pin("brk_act00", "act", 8'h00);
        repeat (3) send_byte(CM);
        pin("brk_act3", "act", 8'h00);
        send_byte(CM);
        pin("brk_act4", "act", 8'h01);
        send_byte(8'h11);
        pin("brk_dat", "dat", 8'h11);

        // Idle commas while synced: AA BC BC 33
        send_byte(8'hAA);
        pin("idl_vldAA", "vld", 8'h01);
        send_byte(CM);
        pin("idl_vldBC1", "vld", 8'h00);
        pin("idl_stbBC1", "stb", 8'h01);
        pin("idl_datBC1", "dat", 8'hAA);
        send_byte(CM);
        pin("idl_datBC2", "dat", 8'hAA);
        pin("idl_stbBC2", "stb", 8'h01);
        send_byte(8'h33);
        pin("idl_dat33", "dat", 8'h33);
        pin("idl_vld33", "vld", 8'h01);

        // Reset for one cycle at bit 4 of a data word while synced
        send_bits(8'h44, 7, 4);
        tick(1'b1, 1'b1);
        pin("mid_act", "act", 8'h00);
        pin("mid_dat", "dat", 8'h00);
        pin("mid_vld", "vld", 8'h00);
        pin("mid_stb", "stb", 8'h00);
        repeat (3) send_byte(CM);
        send_bits(CM, 7, 1);
        pin("mid_act31", "act", 8'h00);
        send_bits(CM, 0, 0);
        pin("mid_act32", "act", 8'h01);

        // Randomized streams: random phase, random comma run length, data mixed with idles
        for (int seg = 0; seg < 12; seg++) begin
            do_reset(1 + int'($urandom_range(2)));
            repeat ($urandom_range(15)) tick(1'($urandom), 1'b0);
            repeat (2 + $urandom_range(4)) send_byte(CM);
            if ($urandom_range(3) == 0) begin
                send_byte(8'($urandom));
                repeat (4) send_byte(CM);
            end
            for (int w = 0; w < 30; w++) begin
                if ($urandom_range(9) < 3) send_byte(CM);
                else send_byte(8'($urandom));
            end
        end

        tick(1'b0, 1'b0);
        @(negedge clk_8f);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
